// File: rtl/fre_display.sv
`default_nettype none
// ============================================================================
// Module   : fre_display
// Purpose  : Converts a 14-bit measured frequency to four BCD digits with a
//            sequential double-dabble engine, then scans them onto a 4-digit
//            common-anode 7-segment display (active-low enables/segments).
// Revision : 1.0 - initial release
// ============================================================================
module fre_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] Fre,
    input  logic        Fre_vld,
    output logic        busy,
    output logic [15:0] bcd_out,
    output logic        bcd_vld,
    output logic        Ovf,
    output logic [11:0] Seg
);

    localparam int                C_DIV_W     = $clog2(SCAN_DIV);
    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]        C_LAST_ITER = 4'd13;
    localparam logic [13:0]       C_MAX_DISP  = 14'd9999;
    localparam logic [7:0]        C_SEG_BLANK = 8'hFF;
    localparam logic [7:0]        C_SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [13:0]         bin_q, bin_d;
    logic [15:0]         scr_q, scr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ovf_flag_q, ovf_flag_d;
    logic                busy_q, busy_d;
    logic [15:0]         bcd_q, bcd_d;
    logic                vld_q, vld_d;
    logic                ovf_q, ovf_d;
    logic [C_DIV_W-1:0]  div_q, div_d;
    logic [1:0]          idx_q, idx_d;
    logic [11:0]         seg_q, seg_d;

    logic [15:0]         w_adj;
    logic [29:0]         w_shl;
    logic                w_div_tc;
    logic [3:0]          w_nz;
    logic [3:0]          w_digit;
    logic                w_blank;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = C_SEG_BLANK;
        endcase
    endfunction

    // Converter FSM: capture on strobe, 14 add-3/shift iterations, publish result
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        vld_d      = 1'b0;
        w_adj      = scr_q;
        for (int i = 0; i < 4; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        w_shl = {w_adj, bin_q} << 1;
        case (state_q)
            ST_IDLE: begin
                if (Fre_vld) begin
                    bin_d      = Fre;
                    scr_d      = '0;
                    cnt_d      = '0;
                    ovf_flag_d = (Fre > C_MAX_DISP);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scr_d = w_shl[29:14];
                bin_d = w_shl[13:0];
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == C_LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = ovf_flag_q ? 16'h9999 : scr_q;
                ovf_d   = ovf_flag_q;
                vld_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Scan: free-running divider, digit rotation and registered segment drive.
    // bcd_q/ovf_q double as the display register, so all digits change together.
    always_comb begin
        w_div_tc = (div_q == C_DIV_LAST);
        div_d    = w_div_tc ? '0 : div_q + 1'b1;
        idx_d    = w_div_tc ? idx_q + 2'd1 : idx_q;
        for (int k = 0; k < 4; k++) begin
            w_nz[k] = |bcd_q[4*k +: 4];
        end
        case (idx_d)
            2'd0: begin
                w_digit = bcd_q[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_digit = bcd_q[7:4];
                w_blank = ~|w_nz[3:1];
            end
            2'd2: begin
                w_digit = bcd_q[11:8];
                w_blank = ~|w_nz[3:2];
            end
            default: begin
                w_digit = bcd_q[15:12];
                w_blank = ~w_nz[3];
            end
        endcase
        seg_d = seg_q;
        if (w_div_tc) begin
            seg_d[11:8] = ~(4'b0001 << idx_d);
            if (ovf_q) begin
                seg_d[7:0] = C_SEG_DASH;
            end else if (w_blank) begin
                seg_d[7:0] = C_SEG_BLANK;
            end else begin
                seg_d[7:0] = seg_code(w_digit);
            end
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            bcd_q      <= '0;
            vld_q      <= 1'b0;
            ovf_q      <= 1'b0;
            div_q      <= '0;
            idx_q      <= '0;
            seg_q      <= 12'hFFF;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            busy_q     <= busy_d;
            bcd_q      <= bcd_d;
            vld_q      <= vld_d;
            ovf_q      <= ovf_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
        end
    end

    assign busy    = busy_q;
    assign bcd_out = bcd_q;
    assign bcd_vld = vld_q;
    assign Ovf     = ovf_q;
    assign Seg     = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_fre_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_fre_display
// Purpose  : Self-checking bench for fre_display: directed and random
//            conversions compared against an arithmetic reference model of
//            the BCD result, overflow flag and scanned segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fre_display;

    localparam int SD = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic [13:0] Fre     = '0;
    logic        Fre_vld = 1'b0;
    logic        busy;
    logic [15:0] bcd_out;
    logic        bcd_vld;
    logic        Ovf;
    logic [11:0] Seg;

    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_n   = 0;
    logic [11:0] exp_seg  = 12'hFFF;
    int          mdl_val  = 0;
    bit          mdl_ovf  = 1'b0;

    fre_display #(.SCAN_DIV(SD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Fre     (Fre),
        .Fre_vld (Fre_vld),
        .busy    (busy),
        .bcd_out (bcd_out),
        .bcd_vld (bcd_vld),
        .Ovf     (Ovf),
        .Seg     (Seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] digit_code(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    // Expected Seg for digit slot k showing decimal value val
    function automatic logic [11:0] model_seg(input int val, input bit ovf, input int k);
        logic [3:0] en;
        logic [7:0] s;
        int         p;
        en    = 4'hF;
        en[k] = 1'b0;
        p     = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        if (ovf)                  s = 8'hBF;
        else if (k > 0 && val < p) s = 8'hFF;
        else                       s = digit_code((val / p) % 10);
        return {en, s};
    endfunction

    function automatic logic [15:0] exp_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One clock; tracks the scan position and checks Seg every cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) begin
            edge_n++;
            if (edge_n % SD == 0) exp_seg = model_seg(mdl_val, mdl_ovf, (edge_n / SD) % 4);
        end
        chk("seg", 32'(Seg), 32'(exp_seg));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("vld_idle", 32'(bcd_vld), 0);
            chk("busy_idle", 32'(busy), 0);
        end
    endtask

    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bcd", 32'(bcd_out), 0);
        chk("rst_vld", 32'(bcd_vld), 0);
        chk("rst_ovf", 32'(Ovf), 0);
        chk("rst_seg", 32'(Seg), 32'h0FFF);
        edge_n  = 0;
        exp_seg = 12'hFFF;
        mdl_val = 0;
        mdl_ovf = 1'b0;
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    // Strobe v at E0 (or assume it was accepted already when pre=1); optional
    // ignored strobe at edge mid_at (1..15) and optional chained strobe at E16.
    task automatic run_conv(input int v, input int mid_at, input int mid_v,
                            input bit chain, input int chain_v, input bit pre);
        logic [15:0] eb;
        bit          eo;
        eb = exp_bcd(v);
        eo = (v > 9999);
        if (!pre) begin
            Fre     = 14'(v);
            Fre_vld = 1'b1;
            tick();
        end
        Fre_vld = 1'b0;
        chk("busy_e0", 32'(busy), 1);
        for (int k = 1; k <= 16; k++) begin
            if (k == mid_at) begin
                Fre     = 14'(mid_v);
                Fre_vld = 1'b1;
            end else if (k == 16 && chain) begin
                Fre     = 14'(chain_v);
                Fre_vld = 1'b1;
            end else begin
                Fre_vld = 1'b0;
            end
            tick();
            if (k < 15) begin
                chk("busy_run", 32'(busy), 1);
                chk("vld_early", 32'(bcd_vld), 0);
            end else if (k == 15) begin
                chk("vld_e15", 32'(bcd_vld), 1);
                chk("bcd_out", 32'(bcd_out), 32'(eb));
                chk("ovf", 32'(Ovf), 32'(eo));
                chk("busy_e15", 32'(busy), 0);
                mdl_val = eo ? 9999 : v;
                mdl_ovf = eo;
            end else begin
                chk("vld_e16", 32'(bcd_vld), 0);
                chk("busy_e16", 32'(busy), chain ? 1 : 0);
            end
        end
        Fre_vld = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        chk("por_busy", 32'(busy), 0);
        chk("por_bcd", 32'(bcd_out), 0);
        chk("por_vld", 32'(bcd_vld), 0);
        chk("por_ovf", 32'(Ovf), 0);
        chk("por_seg", 32'(Seg), 32'h0FFF);
        #5 rst_n = 1'b1;

        gap(SD + 2);

        // Directed values: latency, range edges and blanking
        run_conv(1234, 0, 0, 0, 0, 0);  gap(4 * SD + 2);
        run_conv(9999, 0, 0, 0, 0, 0);  gap(4 * SD + 2);
        run_conv(10000, 0, 0, 0, 0, 0); gap(4 * SD + 2);
        run_conv(0, 0, 0, 0, 0, 0);     gap(4 * SD + 2);
        run_conv(57, 0, 0, 0, 0, 0);    gap(4 * SD + 2);
        run_conv(16383, 0, 0, 0, 0, 0); gap(4 * SD + 2);
        run_conv(8888, 0, 0, 0, 0, 0);  gap(8 * SD + 1);

        // Asynchronous reset with a value on the display
        async_reset();
        gap(SD + 3);

        // Strobe while busy (E5 ignored), then chained strobe at E16
        run_conv(4321, 5, 1111, 1, 1111, 0);
        run_conv(1111, 0, 0, 0, 0, 1);
        gap(4 * SD);
        // Strobe during the DONE cycle is ignored
        run_conv(700, 15, 1111, 0, 0, 0);
        gap(4 * SD);

        // Reset in the middle of a conversion
        Fre     = 14'd2000;
        Fre_vld = 1'b1;
        tick();
        Fre_vld = 1'b0;
        chk("busy_abort", 32'(busy), 1);
        for (int i = 0; i < 6; i++) tick();
        async_reset();
        gap(20);
        chk("bcd_abort", 32'(bcd_out), 0);
        run_conv(3000, 0, 0, 0, 0, 0);
        gap(4 * SD);

        // Random conversions
        for (int n = 0; n < 25; n++) begin
            int v, mid, mv, cv;
            bit ch;
            v   = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9999))
                                              : int'($urandom_range(0, 16383));
            mid = $urandom_range(0, 15);
            mv  = $urandom_range(0, 16383);
            ch  = ($urandom_range(0, 3) == 0);
            cv  = $urandom_range(0, 16383);
            run_conv(v, mid, mv, ch, cv, 0);
            if (ch) run_conv(cv, 0, 0, 0, 0, 1);
            gap($urandom_range(4 * SD, 6 * SD));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fre_display.md
# fre_display

Consumer of the frequency-measurement stage's 14-bit result: converts the measured frequency to four BCD digits with a sequential double-dabble engine, then drives a time-multiplexed 4-digit common-anode 7-segment display on the 12-bit `Seg` bus.

- Conversion runs only on a valid strobe.
- The scan runs continuously from a free-running divider.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot; legal range ≥ 2.
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous active-low reset; one clock; polarity and synchronicity fixed.
- `Fre` input 14: measured frequency, unsigned binary.
- `Fre_vld` input 1: one-cycle strobe; `Fre` is valid when high.
- `busy` output 1: conversion in progress.
- `bcd_out` output 16: four BCD digits {thousands, hundreds, tens, ones}.
- `bcd_vld` output 1: one-cycle pulse when `bcd_out`/`Ovf` update.
- `Ovf` output 1: the last captured `Fre` exceeded 9999.
- `Seg` output 12:
  - `Seg[11:8]`: digit enables, active-low; bit 8 = ones (rightmost).
  - `Seg[7:0]`: segments, active-low, ordered {dp,g,f,e,d,c,b,a}.

## Operation
- Converter FSM states:
  - **IDLE**: on `Fre_vld`=1, capture `Fre` into the shift register, clear the BCD scratch, set the overflow flag = (`Fre` > 9999), go to SHIFT with iteration count 0.
  - **SHIFT**: each cycle, add 3 to every scratch BCD nibble ≥ 5, then shift {scratch, binary} left 1. Run 14 iterations, then go to DONE.
  - **DONE**: load `bcd_out` from the scratch (16'h9999 if overflow), load `Ovf`, pulse `bcd_vld`, return to IDLE.
- `Fre_vld` outside IDLE is ignored; the conversion in progress is not disturbed and the dropped strobe leaves no trace.
- Display register: holds `bcd_out`/`Ovf`. It changes only on the `bcd_vld` edge, so all four digits update atomically.
- Scan:
  - Divider counts 0..`SCAN_DIV`-1 and wraps.
  - On the terminal count, the digit index advances 0→1→2→3→0 and `Seg` is re-registered for the new index.
- Segment codes:
  - Digits 0–9 = C0,F9,A4,B0,99,92,82,F8,80,90 (hex).
  - Blank = FF.
  - Dash = BF.
  - dp always off.
- Leading-zero blanking: a digit above the most significant nonzero digit is blank. The ones digit is never blanked, so value 0 shows a single "0".
- `Ovf`=1: all four digits show dash.
- Digit enable: index k drives `Seg[8+k]`=0 and the other enables =1.

## Timing
- Reset values (asynchronous, immediate):
  - FSM=IDLE, `busy`=0, `bcd_out`=0, `bcd_vld`=0, `Ovf`=0.
  - Display register = 0, divider = 0, digit index = 0, `Seg`=12'hFFF (all dark).
- Edge E0 samples `Fre_vld`=1 in IDLE.
  - `busy`=1 after E0.
  - SHIFT occupies edges E1–E14.
  - DONE is registered at E15.
  - `bcd_out`, `Ovf`, `bcd_vld`=1 are visible after E15; `busy`=0 after E15.
  - `bcd_vld` is low again after E16.
  - Latency: 15 clocks strobe-to-result. Maximum accepted strobe rate: one per 16 clocks; a strobe at E16 is accepted.
- Display register loads at the same edge as `bcd_out` (E15). `Seg` reflects the new value at the next scan terminal count.
- First `Seg` update after reset: edge `SCAN_DIV` (digit index 1). Before that, `Seg` stays FFF.
- All outputs are registered; none are combinational from inputs.
- Reset mid-conversion aborts and returns to the reset values; no `bcd_vld` is generated.
- `Fre` = 0: converts normally to 16'h0000, `Ovf`=0.
- `Fre` = 9999: `Ovf`=0. `Fre` = 10000..16383: `Ovf`=1.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run, asynchronously, away from an edge → all outputs at their reset values immediately. Release, then run `SCAN_DIV`-1 clocks → `Seg`=FFF throughout.
- **Latency:** `Fre`=1234 strobe at E0 → `busy` high E0–E15; `bcd_out`=16'h1234, `Ovf`=0, single `bcd_vld` pulse after E15.
- **Range and blanking** (`SCAN_DIV`=4, one full scan per case):
  - `Fre`=9999 → digits 0–3 all code 90, `Ovf`=0.
  - `Fre`=10000 → `Ovf`=1, `bcd_out`=16'h9999, all four digits show BF.
  - `Fre`=0 → ones digit C0, other digits FF.
  - `Fre`=57 → ones F8, tens 92, hundreds and thousands FF.
- **Strobe while busy:** `Fre`=4321 at E0, then `Fre`=1111 strobed at E5 → exactly one `bcd_vld`, `bcd_out`=16'h4321. A strobe at E16 with 1111 → second result 16'h1111.
- **Scan rotation** (`SCAN_DIV`=4, value 8888): `Seg[11:8]` sequence E,D,B,7,E,... changes every 4 clocks; segments = 80 on every digit.
- **Reset mid-conversion:** `Fre`=2000 strobed, reset pulsed at E7 → no `bcd_vld`, `bcd_out`=0, `busy`=0. A new strobe after release with 3000 → 16'h3000 at the normal latency.
